// File: rtl/sram_arbiter_pkg.sv
// Shared types and limits for the SRAM arbiter slice: FSM state encoding,
// counter widths and the bound on strobe length.
package sram_arbiter_pkg;

  localparam int STATE_W      = 2;
  localparam int WAIT_CNT_W   = 4;
  localparam int WAIT_CYC_MAX = 15;
  localparam int GRANT_W      = 2;
  localparam int STAT_W       = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    SETUP,
    STROBE,
    RECOVER
  } state_e;

  // Keeps the strobe length inside what the 4-bit down-counter can express.
  function automatic int clamp_wait(input int cyc);
    if (cyc < 1) return 1;
    if (cyc > WAIT_CYC_MAX) return WAIT_CYC_MAX;
    return cyc;
  endfunction

endpackage

// File: rtl/sram_arbiter_pick.sv
// arb_pick: combinational winner selector, fixed priority (lowest index) or
// round-robin search starting at start_i.
module arb_pick
  import sram_arbiter_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int RR_MODE = 0
) (
  input  logic [NUM_CH-1:0]  req_i,
  input  logic [GRANT_W-1:0] start_i,
  output logic               valid_o,
  output logic [GRANT_W-1:0] idx_o
);

  logic [3:0] req_pad;
  logic [2:0] base;
  logic [2:0] cand;

  // Fixed priority is the round-robin search with its start pinned to channel 0.
  always_comb begin
    req_pad               = '0;
    req_pad[NUM_CH-1:0]   = req_i;
    base                  = (RR_MODE != 0) ? {1'b0, start_i} : 3'd0;
    cand                  = '0;
    valid_o               = 1'b0;
    idx_o                 = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = base + 3'(i);
      if (cand >= 3'(NUM_CH)) cand = cand - 3'(NUM_CH);
      if (!valid_o && req_pad[cand[1:0]]) begin
        valid_o = 1'b1;
        idx_o   = cand[1:0];
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// SRAM arbiter: grants one of NUM_CH requesters an asynchronous SRAM access
// with SETUP / STROBE / RECOVER timing. Define SRAM_ARBITER_STATS_EN to add
// per-channel 16-bit ack counters on stat_count.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 2,
  parameter int RR_MODE  = 0
) (
  input  logic                     cpu_clk50,
  input  logic                     cpu_rst,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        we,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH*DATA_W-1:0] wdata,
  output logic [NUM_CH-1:0]        ack,
  output logic [DATA_W-1:0]        rdata,
  output logic                     busy,
  output logic [GRANT_W-1:0]       grant_id,
  output logic                     sram_en,
  output logic                     sram_we,
  output logic                     sram_oe,
  output logic [ADDR_W-1:0]        sram_addr,
  inout  wire  [DATA_W-1:0]        sram_dq
`ifdef SRAM_ARBITER_STATS_EN
  ,
  output logic [NUM_CH*STAT_W-1:0] stat_count
`endif
);

  localparam int WaitCyc = clamp_wait(WAIT_CYC);

  state_e                  state_q, state_d;
  logic [GRANT_W-1:0]      grant_q, grant_d;
  logic [GRANT_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    we_q, we_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    pick_valid;
  logic [GRANT_W-1:0]      pick_idx;

  arb_pick #(
    .NUM_CH (NUM_CH),
    .RR_MODE(RR_MODE)
  ) u_pick (
    .req_i  (req),
    .start_i(rr_ptr_q),
    .valid_o(pick_valid),
    .idx_o  (pick_idx)
  );

  always_ff @(posedge cpu_clk50 or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  // The winner's request is captured once in IDLE; requesters are ignored
  // until the access returns to IDLE, so late or dropped requests cannot
  // disturb an access in flight.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d  = SETUP;
          grant_d  = pick_idx;
          rr_ptr_d = (pick_idx == GRANT_W'(NUM_CH - 1)) ? '0 : pick_idx + GRANT_W'(1);
          for (int c = 0; c < NUM_CH; c++) begin
            if (pick_idx == GRANT_W'(c)) begin
              addr_d  = addr[c*ADDR_W +: ADDR_W];
              we_d    = we[c];
              wdata_d = wdata[c*DATA_W +: DATA_W];
            end
          end
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = WAIT_CNT_W'(WaitCyc);
      end
      STROBE: begin
        if (cnt_q == WAIT_CNT_W'(1)) begin
          state_d = RECOVER;
          if (!we_q) rdata_d = sram_dq;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode straight from the async-reset state so reset releases
  // the SRAM in the same cycle it is asserted.
  always_comb begin
    busy     = (state_q != IDLE);
    sram_en  = !((state_q == SETUP) || (state_q == STROBE));
    sram_we  = !((state_q == STROBE) && we_q);
    sram_oe  = !((state_q == STROBE) && !we_q);
    ack      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if ((state_q == RECOVER) && (grant_q == GRANT_W'(c))) ack[c] = 1'b1;
    end
  end

  assign sram_dq   = (busy && we_q) ? wdata_q : {DATA_W{1'bz}};
  assign sram_addr = addr_q;
  assign rdata     = rdata_q;
  assign grant_id  = grant_q;

`ifdef SRAM_ARBITER_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_CH];

  // Counters wrap naturally from 0xFFFF to 0.
  always_ff @(posedge cpu_clk50 or negedge cpu_rst) begin
    if (!cpu_rst) begin
      for (int c = 0; c < NUM_CH; c++) stat_q[c] <= '0;
    end else if (state_q == RECOVER) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (grant_q == GRANT_W'(c)) stat_q[c] <= stat_q[c] + STAT_W'(1);
      end
    end
  end

  always_comb begin
    stat_count = '0;
    for (int c = 0; c < NUM_CH; c++) stat_count[c*STAT_W +: STAT_W] = stat_q[c];
  end
`endif

endmodule
